prog_counting_clock: RTL and testbench
======================================

PROG_COUNTING_CLOCK -- requirements
Module: prog_counting_clock

Interface
REQ-001 SHALL have parameter COUNTING_BITS, default 16, which sets the width of the event counter.
REQ-002 SHALL have parameter DIV_BITS, default 16, which sets the width of the prescaler and of div_value.
REQ-003 SHALL have port clk_internal  in  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  in  1  1 = prescaler runs, 0 = prescaler and counter hold.
REQ-006 SHALL have port div_value  in  DIV_BITS  divide ratio N; values 0 and 1 both mean N=1.
REQ-007 SHALL have port up_down  in  1  1 = count up, 0 = count down.
REQ-008 SHALL have port modulus  in  COUNTING_BITS  count range 0..modulus-1; 0 selects the full 2^COUNTING_BITS range.
REQ-009 SHALL have port load  in  1  synchronous load request.
REQ-010 SHALL have port load_value  in  COUNTING_BITS  value applied on load.
REQ-011 SHALL have port tick  out  1  one-cycle pulse, once every N enabled cycles.
REQ-012 SHALL have port clk_out  out  1  divided square wave, toggles on each tick, period 2N.
REQ-013 SHALL have port counting  out  COUNTING_BITS  current count.
REQ-014 SHALL have port wrap  out  1  one-cycle pulse on a terminal-count rollover.

Function
REQ-015 SHALL define TOP as modulus-1 when modulus!=0, and as all-ones otherwise.
REQ-016 SHALL, on an edge with enable=1 and prescaler>=N-1, set prescaler to 0 and register tick=1; with enable=1 otherwise, increment the prescaler and register tick=0.
REQ-017 SHALL, on an edge with enable=0, hold the prescaler, counter and clk_out, and register tick=0 and wrap=0.
REQ-018 SHALL toggle clk_out, and advance counting, on the same edge that registers tick=1; counting, tick and wrap are mutually aligned with zero added latency.
REQ-019 SHALL, on an up advance, set counting to 0 with wrap=1 if counting>=TOP, and otherwise increment counting with wrap=0.
REQ-020 SHALL, on a down advance, set counting to TOP with wrap=1 if counting==0, set it to TOP with wrap=0 if counting>TOP, and otherwise decrement it with wrap=0.
REQ-021 SHALL give load priority over an advance on the same edge: counting becomes min(load_value, TOP) and wrap=0.
REQ-022 SHALL act on load regardless of enable, and a load SHALL NOT alter the prescaler, tick or clk_out.
REQ-023 SHALL take effect of a div_value change at the next edge; a prescaler already >= the new N-1 produces tick on that edge, with no extended period.
REQ-024 SHALL keep wrap at 0 on every edge where no rollover occurs.

Reset
REQ-025 SHALL, while reset=1, asynchronously force prescaler=0, counting=0, tick=0, wrap=0 and clk_out=0.
REQ-026 SHALL, after reset deasserts, register the first tick only after N enabled edges, even when reset was applied mid-count.

Configuration
REQ-027 SHALL, when macro PROG_COUNTING_CLOCK_ALARM_EN is defined, add port alarm_value (in, COUNTING_BITS) and port alarm_hit (out, 1).
REQ-028 SHALL, with that macro defined, pulse alarm_hit high for one cycle on each edge where counting is updated (advance or load) to a value equal to alarm_value.
REQ-029 SHALL, with that macro defined, reset alarm_hit to 0.
REQ-030 SHALL, without that macro, omit alarm_value and alarm_hit entirely and add no compare logic.

Verification
REQ-031 SHALL cover: div_value=4, modulus=0, up, enable=1 for 12 cycles -> tick on cycles 4, 8 and 12; counting 1, 2, 3; clk_out 1, 0, 1.
REQ-032 SHALL cover: modulus=10, up, div_value=1, counting=9 -> next edge counting=0 and wrap=1 for exactly one cycle.
REQ-033 SHALL cover: down, modulus=0, COUNTING_BITS=16, counting=0, advance -> counting=16'hFFFF and wrap=1; then load_value=5 asserted together with a tick -> counting=5 and wrap=0.
REQ-034 SHALL cover: div_value changed from 8 to 2 while the prescaler is 5 -> tick on the next edge, then every 2 cycles.
REQ-035 SHALL cover: reset pulsed while counting=7 and clk_out=1 -> all outputs 0 immediately, without a clock edge; first tick after N enabled edges.
REQ-036 SHALL cover, with PROG_COUNTING_CLOCK_ALARM_EN defined: alarm_value=3, count up from 0 -> alarm_hit high for exactly the single cycle in which counting=3.

Source files
------------

// File: rtl/prog_counting_clock.sv
// Programmable prescaler driving a modulo up/down event counter, with tick, divided clock and wrap pulses.
// Optional alarm comparator is enabled by defining PROG_COUNTING_CLOCK_ALARM_EN.
module prog_counting_clock #(
    parameter int COUNTING_BITS = 16,
    parameter int DIV_BITS      = 16
) (
    input  logic                     clk_internal,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [DIV_BITS-1:0]      div_value,
    input  logic                     up_down,
    input  logic [COUNTING_BITS-1:0] modulus,
    input  logic                     load,
    input  logic [COUNTING_BITS-1:0] load_value,
`ifdef PROG_COUNTING_CLOCK_ALARM_EN
    input  logic [COUNTING_BITS-1:0] alarm_value,
    output logic                     alarm_hit,
`endif
    output logic                     tick,
    output logic                     clk_out,
    output logic [COUNTING_BITS-1:0] counting,
    output logic                     wrap
);

    logic [DIV_BITS-1:0]      prescaler;
    logic [DIV_BITS-1:0]      div_limit;
    logic [COUNTING_BITS-1:0] top;
    logic                     period_done;
    logic                     advance;
    logic [COUNTING_BITS-1:0] next_count;
    logic                     next_wrap;

    // div_value of 0 and 1 both collapse to a limit of 0, i.e. a tick every enabled edge.
    assign div_limit   = (div_value <= DIV_BITS'(1)) ? '0 : div_value - DIV_BITS'(1);
    assign top         = (modulus == '0) ? '1 : modulus - COUNTING_BITS'(1);
    assign period_done = (prescaler >= div_limit);
    assign advance     = enable && period_done;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        next_count = counting;
        next_wrap  = 1'b0;
        if (load) begin
            next_count = (load_value > top) ? top : load_value;
        end else if (advance) begin
            if (up_down) begin
                if (counting >= top) begin
                    next_count = '0;
                    next_wrap  = 1'b1;
                end else begin
                    next_count = counting + COUNTING_BITS'(1);
                end
            end else begin
                if (counting == '0) begin
                    next_count = top;
                    next_wrap  = 1'b1;
                end else if (counting > top) begin
                    // A shrunken modulus left the count out of range: re-enter at TOP without a wrap.
                    next_count = top;
                end else begin
                    next_count = counting - COUNTING_BITS'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_internal or posedge reset) begin
        // NOTE: registered state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            prescaler <= '0;
            tick      <= 1'b0;
            clk_out   <= 1'b0;
            counting  <= '0;
            wrap      <= 1'b0;
        end else begin
            if (enable) begin
                if (period_done) begin
                    prescaler <= '0;
                    tick      <= 1'b1;
                    clk_out   <= ~clk_out;
                end else begin
                    prescaler <= prescaler + DIV_BITS'(1);
                    tick      <= 1'b0;
                end
            end else begin
                tick <= 1'b0;
            end
            counting <= next_count;
            wrap     <= next_wrap;
        end
    end

`ifdef PROG_COUNTING_CLOCK_ALARM_EN
    always_ff @(posedge clk_internal or posedge reset) begin
        if (reset) begin
            alarm_hit <= 1'b0;
        end else begin
            alarm_hit <= (load || advance) && (next_count == alarm_value);
        end
    end
`endif

endmodule

// File: tb/tb_prog_counting_clock.sv
// Directed self-checking bench for prog_counting_clock; alarm scenario runs when
// PROG_COUNTING_CLOCK_ALARM_EN is defined.
module tb_prog_counting_clock;

    localparam int CB = 16;
    localparam int DB = 16;

    logic          clk_internal = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [DB-1:0] div_value = '0;
    logic          up_down = 1'b1;
    logic [CB-1:0] modulus = '0;
    logic          load = 1'b0;
    logic [CB-1:0] load_value = '0;
    logic          tick;
    logic          clk_out;
    logic [CB-1:0] counting;
    logic          wrap;
`ifdef PROG_COUNTING_CLOCK_ALARM_EN
    logic [CB-1:0] alarm_value = '0;
    logic          alarm_hit;
`endif

    int compared = 0;
    int mismatched = 0;

    prog_counting_clock #(.COUNTING_BITS(CB), .DIV_BITS(DB)) dut (
        .clk_internal(clk_internal),
        .reset(reset),
        .enable(enable),
        .div_value(div_value),
        .up_down(up_down),
        .modulus(modulus),
        .load(load),
        .load_value(load_value),
`ifdef PROG_COUNTING_CLOCK_ALARM_EN
        .alarm_value(alarm_value),
        .alarm_hit(alarm_hit),
`endif
        .tick(tick),
        .clk_out(clk_out),
        .counting(counting),
        .wrap(wrap)
    );

    always #5 clk_internal = ~clk_internal;

    // Advance one rising edge and settle 1 time unit past it before sampling.
    task automatic step();
        @(posedge clk_internal);
        #1;
    endtask

    // Async reset pulse placed mid-cycle, away from any rising edge.
    task automatic do_reset();
        @(negedge clk_internal);
        enable = 1'b0;
        load   = 1'b0;
        reset  = 1'b1;
        #2;
        reset  = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        compared++; if (counting !== 16'd0) begin $display("FAIL reset_counting got=%0h exp=0", counting); mismatched++; end
        compared++; if ({tick, clk_out, wrap} !== 3'b000) begin $display("FAIL reset_flags got=%b exp=000", {tick, clk_out, wrap}); mismatched++; end
        enable = 1'b1;
        div_value = 16'd1;
        step();
        step();
        compared++; if ({tick, clk_out, counting} !== 18'd0) begin $display("FAIL reset_held got=%0h exp=0", {tick, clk_out, counting}); mismatched++; end
        do_reset();
    endtask

    task automatic test_divide();
        do_reset();
        div_value = 16'd4; modulus = 16'd0; up_down = 1'b1; enable = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            compared++; if (tick !== (k % 4 == 0)) begin $display("FAIL div4_tick cyc=%0d got=%b exp=%b", k, tick, (k % 4 == 0)); mismatched++; end
            compared++; if (counting !== 16'(k / 4)) begin $display("FAIL div4_count cyc=%0d got=%0d exp=%0d", k, counting, k / 4); mismatched++; end
            compared++; if (clk_out !== 1'((k / 4) % 2)) begin $display("FAIL div4_clkout cyc=%0d got=%b exp=%b", k, clk_out, (k / 4) % 2); mismatched++; end
        end
        enable = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            compared++; if ({tick, clk_out, counting} !== {1'b0, 1'b1, 16'd3}) begin $display("FAIL hold cyc=%0d got=%b/%b/%0d exp=0/1/3", k, tick, clk_out, counting); mismatched++; end
        end
    endtask

    task automatic test_wrap_up();
        do_reset();
        modulus = 16'd10; up_down = 1'b1; div_value = 16'd1;
        load = 1'b1; load_value = 16'd9; enable = 1'b0;
        step();
        compared++; if (counting !== 16'd9) begin $display("FAIL load_disabled got=%0d exp=9", counting); mismatched++; end
        load = 1'b0; enable = 1'b1;
        step();
        compared++; if ({counting, wrap} !== {16'd0, 1'b1}) begin $display("FAIL up_wrap got=%0d/%b exp=0/1", counting, wrap); mismatched++; end
        step();
        compared++; if ({counting, wrap} !== {16'd1, 1'b0}) begin $display("FAIL up_after_wrap got=%0d/%b exp=1/0", counting, wrap); mismatched++; end
        load = 1'b1; load_value = 16'd20; enable = 1'b0;
        step();
        compared++; if (counting !== 16'd9) begin $display("FAIL load_clamp got=%0d exp=9", counting); mismatched++; end
        load = 1'b0; modulus = 16'd5; up_down = 1'b0; enable = 1'b1;
        step();
        compared++; if ({counting, wrap} !== {16'd4, 1'b0}) begin $display("FAIL down_above_top got=%0d/%b exp=4/0", counting, wrap); mismatched++; end
    endtask

    task automatic test_down_and_load();
        do_reset();
        up_down = 1'b0; modulus = 16'd0; div_value = 16'd1; enable = 1'b1;
        step();
        compared++; if ({counting, wrap} !== {16'hFFFF, 1'b1}) begin $display("FAIL down_wrap got=%0h/%b exp=ffff/1", counting, wrap); mismatched++; end
        load = 1'b1; load_value = 16'd5;
        step();
        compared++; if ({counting, wrap} !== {16'd5, 1'b0}) begin $display("FAIL load_over_tick got=%0d/%b exp=5/0", counting, wrap); mismatched++; end
        compared++; if ({tick, clk_out} !== 2'b10) begin $display("FAIL load_keeps_tick got=%b%b exp=10", tick, clk_out); mismatched++; end
        load = 1'b0;
        step();
        compared++; if ({counting, wrap} !== {16'd4, 1'b0}) begin $display("FAIL down_step got=%0d/%b exp=4/0", counting, wrap); mismatched++; end
    endtask

    task automatic test_div_change();
        logic [5:0] exp_tick;
        logic [CB-1:0] exp_cnt [6];
        exp_tick = 6'b010101;
        exp_cnt = '{16'd1, 16'd1, 16'd2, 16'd2, 16'd3, 16'd3};
        do_reset();
        div_value = 16'd8; modulus = 16'd0; up_down = 1'b1; enable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            compared++; if (tick !== 1'b0) begin $display("FAIL div8_pre cyc=%0d got=%b exp=0", k, tick); mismatched++; end
        end
        div_value = 16'd2;
        for (int k = 0; k < 6; k++) begin
            step();
            compared++; if (tick !== exp_tick[k]) begin $display("FAIL div_change_tick cyc=%0d got=%b exp=%b", k, tick, exp_tick[k]); mismatched++; end
            compared++; if (counting !== exp_cnt[k]) begin $display("FAIL div_change_count cyc=%0d got=%0d exp=%0d", k, counting, exp_cnt[k]); mismatched++; end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        div_value = 16'd1; modulus = 16'd0; up_down = 1'b1; enable = 1'b1;
        repeat (7) step();
        compared++; if ({counting, clk_out} !== {16'd7, 1'b1}) begin $display("FAIL pre_reset got=%0d/%b exp=7/1", counting, clk_out); mismatched++; end
        #2 reset = 1'b1;
        #1;
        compared++; if ({counting, clk_out, tick, wrap} !== 19'd0) begin $display("FAIL async_reset got=%0h exp=0", {counting, clk_out, tick, wrap}); mismatched++; end
        #1 reset = 1'b0;
        div_value = 16'd3;
        for (int k = 1; k <= 3; k++) begin
            step();
            compared++; if (tick !== (k == 3)) begin $display("FAIL post_reset_tick cyc=%0d got=%b exp=%b", k, tick, (k == 3)); mismatched++; end
            compared++; if ({counting, clk_out} !== {16'(k / 3), 1'(k / 3)}) begin $display("FAIL post_reset_count cyc=%0d got=%0d/%b exp=%0d/%0d", k, counting, clk_out, k / 3, k / 3); mismatched++; end
        end
    endtask

`ifdef PROG_COUNTING_CLOCK_ALARM_EN
    task automatic test_alarm();
        do_reset();
        compared++; if (alarm_hit !== 1'b0) begin $display("FAIL alarm_reset got=%b exp=0", alarm_hit); mismatched++; end
        alarm_value = 16'd3; div_value = 16'd1; modulus = 16'd0; up_down = 1'b1; enable = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            compared++; if (alarm_hit !== (k == 3)) begin $display("FAIL alarm cyc=%0d cnt=%0d got=%b exp=%b", k, counting, alarm_hit, (k == 3)); mismatched++; end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_divide();
        test_wrap_up();
        test_down_and_load();
        test_div_change();
        test_async_reset();
`ifdef PROG_COUNTING_CLOCK_ALARM_EN
        test_alarm();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
